// File: rtl/aes_pkg.sv
// Shared AES definitions for the encrypt and decrypt datapaths.
//   byte_t / state_t : one byte, and a 4x4 byte state indexed [row][col]
//   SBOX / INV_SBOX  : forward and inverse substitution tables
//   RCON[1:10]       : round constants for the key schedule
//   xtime, gmul      : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
//   key_step         : round key K(r-1) -> K(r)
//   inv_key_step     : round key K(r)   -> K(r-1)
package aes_pkg;

   typedef logic [7:0] byte_t;
   typedef byte_t [0:3][0:3] state_t;

   typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_ROUND, S_FINAL, S_OUT} fsm_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   localparam logic [1:10][7:0] RCON = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   function automatic byte_t xtime(input byte_t a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic byte_t gmul(input byte_t a, input byte_t b);
      byte_t p = 8'h00;
      byte_t x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Columns are words; the last column of the old key feeds RotWord/SubWord.
   function automatic state_t key_step(input state_t k, input byte_t rc);
      state_t n;
      logic [0:3][7:0] t;
      for (int j = 0; j < 4; j++) t[j] = SBOX[k[(j + 1) % 4][3]];
      t[0] = t[0] ^ rc;
      for (int j = 0; j < 4; j++) begin
         n[j][0] = k[j][0] ^ t[j];
         n[j][1] = k[j][1] ^ n[j][0];
         n[j][2] = k[j][2] ^ n[j][1];
         n[j][3] = k[j][3] ^ n[j][2];
      end
      return n;
   endfunction

   // Undo key_step: recover columns 1..3 first, then column 0 needs the
   // recovered last column for the SubWord term.
   function automatic state_t inv_key_step(input state_t k, input byte_t rc);
      state_t n;
      logic [0:3][7:0] t;
      for (int j = 0; j < 4; j++) begin
         n[j][3] = k[j][3] ^ k[j][2];
         n[j][2] = k[j][2] ^ k[j][1];
         n[j][1] = k[j][1] ^ k[j][0];
      end
      for (int j = 0; j < 4; j++) t[j] = SBOX[n[(j + 1) % 4][3]];
      t[0] = t[0] ^ rc;
      for (int j = 0; j < 4; j++) n[j][0] = k[j][0] ^ t[j];
      return n;
   endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_round.sv
// One inverse AES round, purely combinational.
//   st       : current state
//   rk       : round key added at the start of this round
//   is_first : first inverse round (r=10), which has no InvMixColumns
//   next_st  : InvSubBytes(InvShiftRows([InvMixColumns](st ^ rk)))
module aes_inv_round
   import aes_pkg::*;
(
   input  state_t st,
   input  state_t rk,
   input  logic   is_first,
   output state_t next_st
);

   state_t t;
   state_t m;

   always_comb begin
      t = st ^ rk;
      m = t;
      if (!is_first) begin
         for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
               m[r][c] = gmul(t[r][c], 8'h0e) ^ gmul(t[(r + 1) % 4][c], 8'h0b) ^
                         gmul(t[(r + 2) % 4][c], 8'h0d) ^ gmul(t[(r + 3) % 4][c], 8'h09);
            end
         end
      end
      next_st = '0;
      // row r rotates right by r, then each byte goes through the inverse S-box
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            next_st[r][c] = INV_SBOX[m[r][(c + 4 - r) % 4]];
         end
      end
   end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: one block plus key in over valid/ready, key expanded
// forward to K10, ten inverse rounds one per clock, plaintext out over valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (ready only in IDLE)
//   ct_in, key_in       : ciphertext and cipher key, [row][col]
//   out_valid/out_ready : output handshake
//   pt_out              : plaintext, held stable while out_valid=1
//   KEY_CACHE           : 1 keeps the last key and its K10 so a repeated key skips expansion
//
// state    | meaning
// S_IDLE   | waiting for a block, in_ready=1
// S_KEYEXP | forward key expansion K0 -> K10, i=1..10
// S_ROUND  | inverse rounds r=10..1, round key walked back to K0
// S_FINAL  | last AddRoundKey with K0 into pt_out
// S_OUT    | plaintext presented until out_ready
module aes_inv_cipher_iter
   import aes_pkg::*;
#(
   parameter bit KEY_CACHE = 1'b1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   in_valid,
   output logic   in_ready,
   input  state_t ct_in,
   input  state_t key_in,
   output logic   out_valid,
   input  logic   out_ready,
   output state_t pt_out
);

   fsm_t       state, state_nx;
   state_t     st, rk, rnd_st, exp_rk;
   logic [3:0] i_cnt, r_cnt;
   state_t     cache_key, cache_k10;
   logic       cache_vld;
   logic       accept, cache_hit;

   assign in_ready  = (state == S_IDLE);
   assign accept    = in_valid && in_ready;
   assign cache_hit = KEY_CACHE && cache_vld && (key_in == cache_key);
   assign exp_rk    = key_step(rk, RCON[i_cnt]);

   aes_inv_round u_round (
      .st       (st),
      .rk       (rk),
      .is_first (r_cnt == 4'd10),
      .next_st  (rnd_st)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (accept) state_nx = cache_hit ? S_ROUND : S_KEYEXP;
         S_KEYEXP: if (i_cnt == 4'd10) state_nx = S_ROUND;
         S_ROUND:  if (r_cnt == 4'd1) state_nx = S_FINAL;
         S_FINAL:  state_nx = S_OUT;
         S_OUT:    if (out_ready) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= '0;
         rk        <= '0;
         i_cnt     <= 4'd0;
         r_cnt     <= 4'd0;
         pt_out    <= '0;
         out_valid <= 1'b0;
         cache_key <= '0;
         cache_k10 <= '0;
         cache_vld <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  st <= ct_in;
                  if (cache_hit) begin
                     rk    <= cache_k10;
                     r_cnt <= 4'd10;
                  end else begin
                     rk        <= key_in;
                     i_cnt     <= 4'd1;
                     // the cache only becomes valid once K10 for this key exists
                     cache_key <= key_in;
                     cache_vld <= 1'b0;
                  end
               end
            end
            S_KEYEXP: begin
               rk <= exp_rk;
               if (i_cnt == 4'd10) begin
                  cache_k10 <= exp_rk;
                  cache_vld <= 1'b1;
                  i_cnt     <= 4'd0;
                  r_cnt     <= 4'd10;
               end else begin
                  i_cnt <= i_cnt + 4'd1;
               end
            end
            S_ROUND: begin
               st    <= rnd_st;
               rk    <= inv_key_step(rk, RCON[r_cnt]);
               r_cnt <= r_cnt - 4'd1;
            end
            S_FINAL: begin
               pt_out    <= st ^ rk;
               out_valid <= 1'b1;
            end
            S_OUT: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
module tb_aes_inv_cipher_iter;
   import aes_pkg::*;

   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2  = 128'h5468617473206d79204b756e67204675;
   localparam logic [127:0] CT2 = 128'h29c3505f571420f6402299b31a02d73a;
   localparam logic [127:0] PT2 = 128'h54776f204f6e65204e696e652054776f;

   logic   clk = 1'b0;
   logic   rst;
   logic   in_valid, in_ready, out_valid, out_ready;
   state_t ct_in, key_in, pt_out;
   logic   nc_in_valid, nc_in_ready, nc_out_valid, nc_out_ready;
   state_t nc_ct_in, nc_key_in, nc_pt_out;

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      state_t pt;
      int     lat;
      int     acc;
   } exp_t;

   exp_t   q0[$];
   exp_t   q1[$];
   logic   prev_ov[2];
   state_t cur_pt[2];
   int     hs_cyc[2];

   aes_inv_cipher_iter #(.KEY_CACHE(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ct_in(ct_in), .key_in(key_in), .out_valid(out_valid),
      .out_ready(out_ready), .pt_out(pt_out));

   aes_inv_cipher_iter #(.KEY_CACHE(1'b0)) dut_nc (
      .clk(clk), .rst(rst), .in_valid(nc_in_valid), .in_ready(nc_in_ready),
      .ct_in(nc_ct_in), .key_in(nc_key_in), .out_valid(nc_out_valid),
      .out_ready(nc_out_ready), .pt_out(nc_pt_out));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic state_t h2s(input logic [127:0] h);
      state_t s;
      for (int i = 0; i < 16; i++) s[i % 4][i / 4] = h[127 - 8 * i -: 8];
      return s;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a block, wait for the accept edge, queue the expected result.
   task automatic send(input bit w, input logic [127:0] ct_h, input logic [127:0] key_h,
                       input logic [127:0] pt_h, input int lat, input bit push,
                       input bit hold, output int acc);
      exp_t e;
      bit   ok = 1'b0;
      int   guard = 0;
      if (!w) begin
         in_valid = 1'b1; ct_in = h2s(ct_h); key_in = h2s(key_h);
      end else begin
         nc_in_valid = 1'b1; nc_ct_in = h2s(ct_h); nc_key_in = h2s(key_h);
      end
      while (!ok && guard < 100) begin
         ok = w ? nc_in_ready : in_ready;
         tick();
         guard++;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      acc = cyc;
      e.pt = h2s(pt_h); e.lat = lat; e.acc = acc;
      if (push) begin
         if (!w) q0.push_back(e);
         else    q1.push_back(e);
      end
      if (!hold) begin
         if (!w) in_valid = 1'b0;
         else    nc_in_valid = 1'b0;
      end
   endtask

   task automatic drain(input bit w);
      int guard = 0;
      while (guard < 200 && ((w ? q1.size() : q0.size()) != 0 || (w ? nc_out_valid : out_valid))) begin
         tick();
         guard++;
      end
      if (guard >= 200) chk("drain_timeout", 0, 1);
   endtask

   // Scoreboard monitor: checks each output against the queued expectation.
   always @(negedge clk) begin
      logic   ov, ir, ordy;
      state_t pt;
      exp_t   e;
      for (int w = 0; w < 2; w++) begin
         ov   = w ? nc_out_valid : out_valid;
         ir   = w ? nc_in_ready  : in_ready;
         ordy = w ? nc_out_ready : out_ready;
         pt   = w ? nc_pt_out    : pt_out;
         if (rst) begin
            prev_ov[w] = 1'b0;
         end else begin
            if (ov && !prev_ov[w]) begin
               if ((w ? q1.size() : q0.size()) == 0) begin
                  chk("unexpected_output", 1, 0);
               end else begin
                  if (w) e = q1.pop_front();
                  else   e = q0.pop_front();
                  cur_pt[w] = e.pt;
                  chk(w ? "nc_plaintext" : "plaintext", pt, e.pt);
                  chk(w ? "nc_latency" : "latency", cyc - e.acc, e.lat);
               end
            end else if (ov) begin
               chk("pt_stable", pt, cur_pt[w]);
               chk("in_ready_during_out", {127'd0, ir}, 0);
            end
            if (ov && ordy) hs_cyc[w] = cyc + 1;
            prev_ov[w] = ov;
         end
      end
   end

   initial begin
      int acc, acc2, guard;
      rst = 1'b1;
      in_valid = 1'b0; ct_in = '0; key_in = '0; out_ready = 1'b1;
      nc_in_valid = 1'b0; nc_ct_in = '0; nc_key_in = '0; nc_out_ready = 1'b1;
      hs_cyc[0] = 0; hs_cyc[1] = 0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_out_valid", {127'd0, out_valid}, 0);
      chk("reset_pt_out", pt_out, 0);
      chk("reset_in_ready", {127'd0, in_ready}, 1);
      chk("reset_nc_in_ready", {127'd0, nc_in_ready}, 1);

      // FIPS-197 C.1, then key-cache miss and hit
      send(0, CT1, K1, PT1, 21, 1, 0, acc);  drain(0);
      send(0, CT2, K2, PT2, 21, 1, 0, acc);  drain(0);
      send(0, CT2, K2, PT2, 11, 1, 0, acc);  drain(0);

      // backpressure, then a queued block that must wait for the handshake
      out_ready = 1'b0;
      send(0, CT2, K2, PT2, 11, 1, 0, acc);
      guard = 0;
      while (!out_valid && guard < 50) begin tick(); guard++; end
      repeat (5) tick();
      chk("bp_out_valid_held", {127'd0, out_valid}, 1);
      chk("bp_in_ready_low", {127'd0, in_ready}, 0);
      out_ready = 1'b1;
      send(0, CT1, K1, PT1, 21, 1, 0, acc2);
      chk("accept_after_handshake", acc2 - hs_cyc[0], 1);
      drain(0);

      // reset mid-ROUND clears the cache
      send(0, CT2, K2, PT2, 21, 0, 0, acc);
      while (cyc < acc + 14) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midreset_out_valid", {127'd0, out_valid}, 0);
      chk("midreset_pt_out", pt_out, 0);
      chk("midreset_in_ready", {127'd0, in_ready}, 1);
      send(0, CT2, K2, PT2, 21, 1, 0, acc);  drain(0);

      // inputs scrambled while busy with in_valid still asserted
      send(0, CT1, K1, PT1, 21, 1, 1, acc);
      guard = 0;
      while (!out_valid && guard < 50) begin
         ct_in  = {$urandom, $urandom, $urandom, $urandom};
         key_in = {$urandom, $urandom, $urandom, $urandom};
         tick();
         guard++;
      end
      in_valid = 1'b0;
      drain(0);

      // no key cache: every block pays for expansion
      send(1, CT2, K2, PT2, 21, 1, 0, acc);  drain(1);
      send(1, CT2, K2, PT2, 21, 1, 0, acc);  drain(1);

      repeat (3) tick();
      chk("queue0_empty", q0.size(), 0);
      chk("queue1_empty", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
